// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the unified-memory bus arbiter: FSM states, bus owner
// encoding and the alternating-priority grant helper.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IBUS = 1'b0,
    OWN_DBUS = 1'b1
  } arb_owner_t;

  // A lone requester always wins; contention goes to whoever was not served last.
  function automatic arb_owner_t pick_owner(input logic ibus_req,
                                            input logic dbus_req,
                                            input arb_owner_t last_owner);
    arb_owner_t winner;
    if (ibus_req && dbus_req) begin
      winner = (last_owner == OWN_DBUS) ? OWN_IBUS : OWN_DBUS;
    end else if (ibus_req) begin
      winner = OWN_IBUS;
    end else begin
      winner = OWN_DBUS;
    end
    return winner;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter.sv
// Arbiter sharing one fixed-latency single-port memory between a read-only
// instruction bus and a read/write data bus, with alternating priority on contention.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_ibus_req,
  input  logic [ADDR_WIDTH-1:0] i_ibus_addr,
  output logic [DATA_WIDTH-1:0] o_ibus_rdata,
  output logic                  o_ibus_ack,
  input  logic                  i_dbus_req,
  input  logic                  i_dbus_we,
  input  logic [ADDR_WIDTH-1:0] i_dbus_addr,
  input  logic [DATA_WIDTH-1:0] i_dbus_wdata,
  output logic [DATA_WIDTH-1:0] o_dbus_rdata,
  output logic                  o_dbus_ack,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic                  o_mem_we,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  output arb_state_t            o_dbg_state
);

  // Handshake: a requester raises req with its address/data and holds them until
  // it sees a one-cycle ack. Requests are sampled only in IDLE; the command is
  // registered at grant, so later req/addr/data changes never affect the access.

  localparam int CNT_W = $clog2(MEM_LATENCY + 1);

  arb_state_t            state_q, state_d;
  arb_owner_t            owner_q, owner_d;
  logic                  op_write_q, op_write_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                  mem_we_q, mem_we_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_WIDTH-1:0] ibus_rdata_q, ibus_rdata_d;
  logic [DATA_WIDTH-1:0] dbus_rdata_q, dbus_rdata_d;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q      <= IDLE;
      owner_q      <= OWN_DBUS;
      op_write_q   <= 1'b0;
      cnt_q        <= '0;
      mem_addr_q   <= '0;
      mem_we_q     <= 1'b0;
      mem_wdata_q  <= '0;
      ibus_rdata_q <= '0;
      dbus_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      op_write_q   <= op_write_d;
      cnt_q        <= cnt_d;
      mem_addr_q   <= mem_addr_d;
      mem_we_q     <= mem_we_d;
      mem_wdata_q  <= mem_wdata_d;
      ibus_rdata_q <= ibus_rdata_d;
      dbus_rdata_q <= dbus_rdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    op_write_d   = op_write_q;
    cnt_d        = cnt_q;
    mem_addr_d   = mem_addr_q;
    mem_we_d     = 1'b0;
    mem_wdata_d  = mem_wdata_q;
    ibus_rdata_d = ibus_rdata_q;
    dbus_rdata_d = dbus_rdata_q;

    case (state_q)
      IDLE: begin
        if (i_ibus_req || i_dbus_req) begin
          // owner_q doubles as last_owner: it only changes at a grant.
          owner_d = pick_owner(i_ibus_req, i_dbus_req, owner_q);
          if (owner_d == OWN_IBUS) begin
            mem_addr_d = i_ibus_addr;
            op_write_d = 1'b0;
          end else begin
            mem_addr_d  = i_dbus_addr;
            mem_wdata_d = i_dbus_wdata;
            op_write_d  = i_dbus_we;
          end
          mem_we_d = op_write_d;
          cnt_d    = CNT_W'(MEM_LATENCY);
          state_d  = ACCESS;
        end
      end

      ACCESS: begin
        if (op_write_q) begin
          state_d = ACK;
        end else if (cnt_q == CNT_W'(1)) begin
          if (owner_q == OWN_IBUS) begin
            ibus_rdata_d = i_mem_rdata;
          end else begin
            dbus_rdata_d = i_mem_rdata;
          end
          state_d = ACK;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ACK: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign o_ibus_ack   = (state_q == ACK) && (owner_q == OWN_IBUS);
  assign o_dbus_ack   = (state_q == ACK) && (owner_q == OWN_DBUS);
  assign o_ibus_rdata = ibus_rdata_q;
  assign o_dbus_rdata = dbus_rdata_q;
  assign o_mem_addr   = mem_addr_q;
  assign o_mem_we     = mem_we_q;
  assign o_mem_wdata  = mem_wdata_q;
  assign o_dbg_state  = state_q;

endmodule
